// File: rtl/exmem_pkg.sv
// Shared types and constants for the word-access adapter to the 256x8 external memory.
package exmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/exmem_word_port_word_pack.sv
// word_pack: byte-lane helpers for splitting a write word and assembling a read word.
//   wdata   in  WORD_W  word being written
//   wr_idx  in  CNT_W   lane to place on the memory write bus
//   cap_idx in  CNT_W   lane that captures the incoming read byte
//   wr_byte out LANE_W  selected write byte
//   lane_en out BYTES_PER_WORD one-hot capture enable
module word_pack
  import exmem_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic [WORD_W-1:0]         wdata,
  input  logic [CNT_W-1:0]          wr_idx,
  input  logic [CNT_W-1:0]          cap_idx,
  output logic [LANE_W-1:0]         wr_byte,
  output logic [BYTES_PER_WORD-1:0] lane_en
);

  // Little-endian lane select and one-hot capture decode.
  always_comb begin
    wr_byte = LANE_W'(wdata >> (32'(wr_idx) * LANE_W));
    lane_en = BYTES_PER_WORD'(1) << cap_idx;
  end

endmodule

// File: rtl/exmem_word_port.sv
// exmem_word_port: sequential byte/word access adapter onto a single 8-bit memory port.
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_write, req_size           1=write / 0=read, 0=byte / 1=word
//   req_addr, req_wdata           start byte address, write data
//   resp_valid, resp_rdata        one-cycle completion pulse and read result
//   mem_adr, mem_writedata,
//   mem_memwrite, mem_memdata     memory port (memory samples on falling edge)
module exmem_word_port
  import exmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_memwrite,
  input  logic [DATA_WIDTH-1:0] mem_memdata
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                size_q, size_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   acc_q, acc_d;

  logic                  ready_d;
  logic                  resp_valid_d;
  logic [WORD_W-1:0]     rdata_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [DATA_WIDTH-1:0] wd_d;
  logic                  mw_d;

  logic [CNT_W-1:0]          wr_idx;
  logic [DATA_WIDTH-1:0]     wr_byte;
  logic [BYTES_PER_WORD-1:0] lane_en;
  logic [WORD_W-1:0]         acc_cap;
  logic                      last;

  // Memory outputs are registered, so the write lane is looked up one step ahead.
  assign wr_idx = CNT_W'(cnt_q + 1'b1);

  word_pack #(.LANE_W(DATA_WIDTH)) u_pack (
    .wdata   (wdata_q),
    .wr_idx  (wr_idx),
    .cap_idx (cnt_q),
    .wr_byte (wr_byte),
    .lane_en (lane_en)
  );

  // Accumulator with the byte arriving at this edge merged into lane cnt.
  always_comb begin
    acc_cap = acc_q;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane_en[i]) acc_cap[i*DATA_WIDTH +: DATA_WIDTH] = mem_memdata;
    end
  end

  assign last = (size_q == SZ_BYTE) || (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = resp_rdata;
    adr_d        = mem_adr;
    wd_d         = '0;
    mw_d         = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          state_d = XFER;
          cnt_d   = '0;
          write_d = req_write;
          size_d  = req_size;
          wdata_d = req_wdata;
          acc_d   = '0;
          ready_d = 1'b0;
          // First byte access is set up directly from the accepted request.
          adr_d   = req_addr;
          mw_d    = req_write;
          wd_d    = req_write ? req_wdata[DATA_WIDTH-1:0] : '0;
        end
      end
      XFER: begin
        if (!write_q) acc_d = acc_cap;
        if (last) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          rdata_d      = write_q ? WORD_W'(0) : acc_cap;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
          adr_d = ADDR_WIDTH'(mem_adr + ADDR_WIDTH'(1));
          mw_d  = write_q;
          wd_d  = write_q ? wr_byte : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      size_q        <= SZ_BYTE;
      wdata_q       <= '0;
      acc_q         <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      mem_memwrite  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      size_q        <= size_d;
      wdata_q       <= wdata_d;
      acc_q         <= acc_d;
      req_ready     <= ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= rdata_d;
      mem_adr       <= adr_d;
      mem_writedata <= wd_d;
      mem_memwrite  <= mw_d;
    end
  end

endmodule
